// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline, directly downstream of EX.
// Latches EX results into the EX/MEM (M) register, decodes load/store opcodes,
// drives the data-memory request/ready handshake (stalling upstream while the
// memory is not ready), aligns/extends load data and registers one result per
// instruction for WB.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   in_valid/in_instr/in_pc/in_res/in_wd/in_rd2 : EX results
//   mem_stall                                   : freeze PC, IF/ID, ID/EX, EX
//   m_req/m_we/m_addr/m_byteen/m_wdata          : data-memory request
//   m_rdata/m_ready                             : data-memory response
//   wb_valid/wb_instr/wb_pc/wb_addr/wb_wd       : registered WB result
//
// Build option: define MEM_UNSIGNED_LOAD_EN to decode lbu/lhu as
// zero-extending loads; otherwise those opcodes pass M.wd through.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_res,
  input  logic [31:0] in_wd,
  input  logic [31:0] in_rd2,
  output logic        mem_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        wb_valid,
  output logic [31:0] wb_instr,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wd
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;

  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_res, m_wd, m_rd2;

  logic [5:0]  op;
  logic        is_lw, is_lh, is_lb, is_lhu, is_lbu;
  logic        is_sw, is_sh, is_sb;
  logic        is_load, is_store, req, done;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  // Opcode decode of the instruction held in M
  assign op = m_instr[31:26];

  always_comb begin
    is_lw = (op == 6'b100011);
    is_lh = (op == 6'b100001);
    is_lb = (op == 6'b100000);
    is_sw = (op == 6'b101011);
    is_sh = (op == 6'b101001);
    is_sb = (op == 6'b101000);
`ifdef MEM_UNSIGNED_LOAD_EN
    is_lbu = (op == 6'b100100);
    is_lhu = (op == 6'b100101);
`else
    is_lbu = 1'b0;
    is_lhu = 1'b0;
`endif
    is_load  = is_lw | is_lh | is_lb | is_lbu | is_lhu;
    is_store = is_sw | is_sh | is_sb;
  end

  assign req  = m_valid & (is_load | is_store);
  // A non-memory op completes at once; a memory op completes on m_ready
  assign done = m_valid & (~(is_load | is_store) | m_ready);

  // Handshake FSM; the request and its fields come straight from M, which is
  // frozen by mem_stall, so they stay stable for the whole WAIT period.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_req     = 1'b0;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          m_req     = 1'b1;
          mem_stall = ~m_ready;
          if (!m_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        m_req     = req;
        mem_stall = req & ~m_ready;
        if (!req || m_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign m_we   = m_req & is_store;
  assign m_addr = {m_res[31:2], 2'b00};

  // Store lane enables and replicated write data
  always_comb begin
    m_byteen = '0;
    m_wdata  = '0;
    if (m_req && is_sw) begin
      m_byteen = 4'b1111;
      m_wdata  = m_rd2;
    end else if (m_req && is_sh) begin
      m_byteen = m_res[1] ? 4'b1100 : 4'b0011;
      m_wdata  = {2{m_rd2[15:0]}};
    end else if (m_req && is_sb) begin
      m_byteen = 4'b0001 << m_res[1:0];
      m_wdata  = {4{m_rd2[7:0]}};
    end
  end

  // Load alignment and extension
  always_comb begin
    half_sel = m_res[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (m_res[1:0])
      2'd0:    byte_sel = m_rdata[7:0];
      2'd1:    byte_sel = m_rdata[15:8];
      2'd2:    byte_sel = m_rdata[23:16];
      default: byte_sel = m_rdata[31:24];
    endcase
    load_data = m_rdata;
    if (is_lh)       load_data = {{16{half_sel[15]}}, half_sel};
    else if (is_lhu) load_data = {16'h0000, half_sel};
    else if (is_lb)  load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (is_lbu) load_data = {24'h000000, byte_sel};
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
    end else if (!mem_stall) begin
      m_valid <= in_valid;
      m_instr <= in_instr;
      m_pc    <= in_pc;
      m_res   <= in_res;
      m_wd    <= in_wd;
      m_rd2   <= in_rd2;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_instr <= '0;
      wb_pc    <= '0;
      wb_addr  <= '0;
      wb_wd    <= '0;
    end else begin
      wb_valid <= done;
      if (done) begin
        wb_instr <= m_instr;
        wb_pc    <= m_pc;
        wb_addr  <= m_res;
        wb_wd    <= is_load ? load_data : m_wd;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage. An instruction-level model tracks
// which instruction sits in the memory stage and what WB must show, and one
// compare process checks every DUT output against it each cycle; selected
// vectors also carry hand-computed literal results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr, in_pc, in_res, in_wd, in_rd2;
  logic        mem_stall, m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_byteen;
  logic        m_ready;
  logic        wb_valid;
  logic [31:0] wb_instr, wb_pc, wb_addr, wb_wd;

  always #5 clk = ~clk;

  mem_stage u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_res(in_res), .in_wd(in_wd), .in_rd2(in_rd2),
    .mem_stall(mem_stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_byteen(m_byteen), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .wb_valid(wb_valid), .wb_instr(wb_instr), .wb_pc(wb_pc),
    .wb_addr(wb_addr), .wb_wd(wb_wd)
  );

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] instr, pc, res, wd, rd2, rdata;
    int          wt;       // cycles before m_ready
    logic        has_lit;
    logic [31:0] lit_wd;
    logic [3:0]  lit_be;   // nonzero: check byteen/wdata literals
    logic [31:0] lit_wdata;
    int          rst_at;   // >0: reset after this many wait cycles
  } vec_t;

  vec_t vt[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic done   = 1'b0;

  // Model expectations
  logic        ex_req, ex_stall, ex_we, ex_st;
  logic [3:0]  ex_be;
  logic [31:0] ex_addr, ex_wdata;
  logic        el_on;
  logic [3:0]  el_be;
  logic [31:0] el_wdata;
  logic        ew_valid, ew_has_lit;
  logic [31:0] ew_instr, ew_pc, ew_addr, ew_wd, ew_lit;

  localparam logic [5:0] OP_LW = 6'b100011, OP_LH = 6'b100001, OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011, OP_SH = 6'b101001, OP_SB = 6'b101000;
  localparam logic [5:0] OP_LBU = 6'b100100, OP_LHU = 6'b100101, OP_ADD = 6'b000000;

  function automatic logic is_ld(logic [5:0] op);
`ifdef MEM_UNSIGNED_LOAD_EN
    if (op == OP_LBU || op == OP_LHU) return 1'b1;
`endif
    return (op == OP_LW || op == OP_LH || op == OP_LB);
  endfunction

  function automatic logic is_st(logic [5:0] op);
    return (op == OP_SW || op == OP_SH || op == OP_SB);
  endfunction

  function automatic logic [31:0] exp_wd(vec_t e);
    logic [31:0] b, h;
    b = (e.rdata >> (8 * e.res[1:0])) & 32'h0000_00FF;
    h = (e.rdata >> (16 * e.res[1])) & 32'h0000_FFFF;
    if (!is_ld(e.op)) return e.wd;
    case (e.op)
      OP_LH:   return (h ^ 32'h8000) - 32'h8000;
      OP_LB:   return (b ^ 32'h80) - 32'h80;
      OP_LHU:  return h;
      OP_LBU:  return b;
      default: return e.rdata;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(vec_t e);
    case (e.op)
      OP_SW:   return 4'hF;
      OP_SH:   return e.res[1] ? 4'hC : 4'h3;
      OP_SB:   return 4'(1 << e.res[1:0]);
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(vec_t e);
    case (e.op)
      OP_SW:   return e.rd2;
      OP_SH:   return {2{e.rd2[15:0]}};
      default: return {4{e.rd2[7:0]}};
    endcase
  endfunction

  task automatic add(input logic v, input logic [5:0] op, input logic [31:0] res,
                     input logic [31:0] wd, input logic [31:0] rd2, input logic [31:0] rdata,
                     input int wt, input logic has_lit, input logic [31:0] lit_wd,
                     input logic [3:0] lit_be, input logic [31:0] lit_wdata, input int rst_at);
    vec_t e;
    e.v = v; e.op = op; e.res = res; e.wd = wd; e.rd2 = rd2; e.rdata = rdata;
    e.wt = wt; e.has_lit = has_lit; e.lit_wd = lit_wd; e.lit_be = lit_be;
    e.lit_wdata = lit_wdata; e.rst_at = rst_at;
    e.pc    = 32'h400 + 32'(4 * vt.size());
    e.instr = {op, 26'(vt.size() * 13 + 5)};
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process
  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      #2;
      if (!done) begin
        chk("mem_stall", 32'(mem_stall), 32'(ex_stall));
        chk("m_req", 32'(m_req), 32'(ex_req));
        chk("m_we", 32'(m_we), 32'(ex_we));
        chk("m_byteen", 32'(m_byteen), 32'(ex_be));
        if (ex_req) chk("m_addr", m_addr, ex_addr);
        if (ex_req && ex_st) chk("m_wdata", m_wdata, ex_wdata);
        if (el_on) begin
          chk("m_byteen_lit", 32'(m_byteen), 32'(el_be));
          chk("m_wdata_lit", m_wdata, el_wdata);
        end
        chk("wb_valid", 32'(wb_valid), 32'(ew_valid));
        chk("wb_instr", wb_instr, ew_instr);
        chk("wb_pc", wb_pc, ew_pc);
        chk("wb_addr", wb_addr, ew_addr);
        chk("wb_wd", wb_wd, ew_wd);
        if (ew_valid && ew_has_lit) chk("wb_wd_lit", wb_wd, ew_lit);
      end
    end
  end

  // Driver and instruction-level model
  initial begin
    vec_t cur;
    logic cur_v, pend, do_rst;
    int   i, waited, cyc;
    logic [31:0] lbu_lit, lhu_lit;

`ifdef MEM_UNSIGNED_LOAD_EN
    lbu_lit = 32'h0000_00F0;
    lhu_lit = 32'h0000_8001;
`else
    lbu_lit = 32'h5555_0013;
    lhu_lit = 32'h5555_0014;
`endif
    //  v  op      res           wd            rd2           rdata         wt lit lit_wd        be     wdata         rst
    add(1, OP_SW,  32'h10,       32'hAAAA0001, 32'h12345678, 32'h0,        0, 0, 32'h0,        4'hF, 32'h12345678, 0);
    add(1, OP_SB,  32'h13,       32'hAAAA0002, 32'h000000AB, 32'h0,        0, 0, 32'h0,        4'h8, 32'hABABABAB, 0);
    add(1, OP_SH,  32'h12,       32'hAAAA0003, 32'h0000BEEF, 32'h0,        1, 0, 32'h0,        4'hC, 32'hBEEFBEEF, 0);
    add(1, OP_LH,  32'h02,       32'hAAAA0004, 32'h0,        32'h80017FFF, 0, 1, 32'hFFFF8001, 4'h0, 32'h0,        0);
    add(1, OP_LB,  32'h01,       32'hAAAA0005, 32'h0,        32'h00007F00, 3, 1, 32'h0000007F, 4'h0, 32'h0,        0);
    add(1, OP_ADD, 32'h0,        32'h11112222, 32'h0,        32'h0,        0, 1, 32'h11112222, 4'h0, 32'h0,        0);
    add(0, OP_LW,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        0);
    add(1, OP_LW,  32'h107,      32'hAAAA0008, 32'h0,        32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 4'h0, 32'h0,        0);
    add(1, OP_LW,  32'h20,       32'hAAAA0009, 32'h0,        32'h01020304, 0, 1, 32'h01020304, 4'h0, 32'h0,        0);
    add(1, OP_LH,  32'h01,       32'hAAAA000A, 32'h0,        32'h12348765, 0, 1, 32'hFFFF8765, 4'h0, 32'h0,        0);
    add(1, OP_LB,  32'h02,       32'hAAAA000B, 32'h0,        32'h00AB0000, 1, 1, 32'hFFFFFFAB, 4'h0, 32'h0,        0);
    add(1, OP_SH,  32'h10,       32'hAAAA000C, 32'h0000CAFE, 32'h0,        0, 0, 32'h0,        4'h3, 32'hCAFECAFE, 0);
    add(1, OP_SB,  32'h02,       32'hAAAA000D, 32'h00000011, 32'h0,        2, 0, 32'h0,        4'h4, 32'h11111111, 0);
    add(1, OP_LBU, 32'h03,       32'h55550013, 32'h0,        32'hF0000000, 0, 1, lbu_lit,      4'h0, 32'h0,        0);
    add(1, OP_LHU, 32'h02,       32'h55550014, 32'h0,        32'h80010000, 1, 1, lhu_lit,      4'h0, 32'h0,        0);
    add(1, OP_LW,  32'h40,       32'hAAAA000F, 32'h0,        32'hCCCCCCCC, 5, 0, 32'h0,        4'h0, 32'h0,        2);
    add(1, OP_ADD, 32'h0,        32'h33334444, 32'h0,        32'h0,        0, 1, 32'h33334444, 4'h0, 32'h0,        0);
    add(0, OP_ADD, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        0);
    add(0, OP_ADD, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        0);

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_res = '0;
    in_wd = '0; in_rd2 = '0; m_ready = 1'b0; m_rdata = '0;
    ex_req = 0; ex_stall = 0; ex_we = 0; ex_st = 0; ex_be = '0; ex_addr = '0; ex_wdata = '0;
    el_on = 0; el_be = '0; el_wdata = '0;
    ew_valid = 0; ew_has_lit = 0; ew_instr = '0; ew_pc = '0; ew_addr = '0; ew_wd = '0; ew_lit = '0;
    cur_v = 1'b0; i = 0; waited = 0; cyc = 0;
    cur = vt[0];
    repeat (2) @(posedge clk);
    chk_en = 1'b1;

    while ((i < vt.size() || cur_v) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      pend   = cur_v && (is_ld(cur.op) || is_st(cur.op));
      do_rst = pend && cur.rst_at > 0 && waited == cur.rst_at;
      reset  = ~do_rst;
      if (do_rst || i >= vt.size()) begin
        in_valid = 1'b0; in_instr = $urandom; in_pc = $urandom;
        in_res = $urandom; in_wd = $urandom; in_rd2 = $urandom;
      end else begin
        in_valid = vt[i].v; in_instr = vt[i].instr; in_pc = vt[i].pc;
        in_res = vt[i].res; in_wd = vt[i].wd; in_rd2 = vt[i].rd2;
      end
      if (pend && (do_rst || waited >= cur.wt)) begin
        m_ready = 1'b1; m_rdata = cur.rdata;
      end else if (pend) begin
        m_ready = 1'b0; m_rdata = $urandom;
      end else begin
        m_ready = 1'($urandom_range(0, 1)); m_rdata = $urandom;
      end
      ex_req   = pend;
      ex_stall = pend && !m_ready;
      ex_st    = pend && is_st(cur.op);
      ex_we    = ex_st;
      ex_be    = pend ? exp_be(cur) : 4'h0;
      ex_addr  = {cur.res[31:2], 2'b00};
      ex_wdata = exp_wdata(cur);
      el_on    = pend && cur.lit_be != 4'h0;
      el_be    = cur.lit_be;
      el_wdata = cur.lit_wdata;

      @(posedge clk);
      if (do_rst) begin
        cur_v = 1'b0; waited = 0;
        ew_valid = 0; ew_has_lit = 0;
        ew_instr = '0; ew_pc = '0; ew_addr = '0; ew_wd = '0;
      end else if (ex_stall) begin
        waited++;
        ew_valid = 0;
      end else begin
        if (cur_v) begin
          ew_valid = 1; ew_instr = cur.instr; ew_pc = cur.pc; ew_addr = cur.res;
          ew_wd = exp_wd(cur); ew_has_lit = cur.has_lit; ew_lit = cur.lit_wd;
        end else begin
          ew_valid = 0;
        end
        if (i < vt.size()) begin
          cur = vt[i]; cur_v = vt[i].v; i++;
        end else begin
          cur_v = 1'b0;
        end
        waited = 0;
      end
    end
    done = 1'b1;
    if (cyc >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d cycles expected fewer than 400", cyc);
    end
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

- Memory stage of the five-stage pipeline; sits directly downstream of EX.
- Latches EX results into the EX/MEM pipeline register and decodes the load/store opcode itself.
- Drives the data-memory request/ready handshake, stalling the pipeline while memory is not ready, and aligns/extends load data.
- Presents one registered result per instruction to WB.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  EX presents an instruction
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- in_res  in  32  ALU result (memory byte address for loads/stores)
- in_wd  in  32  EX-selected write-back data (ALU/HI/LO/link)
- in_rd2  in  32  forwarded rt value (store data)
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX while high
- m_req  out  1  memory request
- m_we  out  1  write request (stores)
- m_addr  out  32  {res[31:2],2'b00}
- m_byteen  out  4  byte write enables; 0000 on loads
- m_wdata  out  32  replicated store data
- m_rdata  in  32  read word, valid when m_ready
- m_ready  in  1  request completes this cycle
- wb_valid, wb_instr, wb_pc, wb_addr, wb_wd  out  1/32/32/32/32  registered WB result

## Operation
- M register holds: valid, instr, pc, res, wd, rd2.
  - Loads from in_* on every edge where mem_stall=0.
  - Holds while mem_stall=1.
- Decoded opcodes:
  - lw 100011, lh 100001, lb 100000 — loads.
  - sw 101011, sh 101001, sb 101000 — stores.
  - Everything else is non-memory.
- FSM, two states:
  - IDLE: if M.valid and M is a memory op, m_req=1. If m_ready=1 in the same cycle, the op completes (zero-wait). Otherwise the next state is WAIT.
  - WAIT: m_req stays 1 and m_addr/m_we/m_byteen/m_wdata are held stable. On m_ready=1, the op completes and the next state is IDLE.
- mem_stall = M.valid & memop & ~m_ready; this is combinational in both states.
- Store byte enables and data:
  - sw: byteen 1111, wdata rd2.
  - sh: byteen res[1]?1100:0011, wdata {rd2[15:0],rd2[15:0]}.
  - sb: byteen 0001<<res[1:0], wdata rd2[7:0] replicated 4 times.
- Load data:
  - lw returns rdata; res[1:0] is ignored.
  - lh selects the halfword at res[1] (res[0] ignored) and sign-extends it.
  - lb selects the byte at res[1:0] and sign-extends it.
- wb_wd = extended load data for loads; M.wd for all other instructions.
- W register update:
  - Loads from M when M completes: a non-memory valid op completes immediately; a memory op completes on m_ready.
  - Otherwise wb_valid<=0 and the other wb_* fields hold.
  - Stores produce wb_valid=1 with wb_wd=M.wd; WB ignores the write.
- Invalid M: no request, no stall, bubble to WB.

## Timing
- Reset (reset=0 at an edge):
  - FSM goes to IDLE; M.valid, wb_valid and all wb_* go to 0.
  - m_req/m_we/m_byteen/mem_stall are 0 from the next cycle.
  - A WAIT in progress is abandoned and no completion is reported.
- Latency:
  - EX→wb_valid is 1 cycle for a non-memory op or zero-wait access.
  - It is 1+N cycles when m_ready arrives N cycles after the first m_req.
- Stall length:
  - mem_stall is high exactly N cycles for N wait cycles.
  - While it is high, the EX input values in_* are not sampled.
- m_ready while m_req=0 is ignored.
- Back-to-back memory ops: the second request is issued the cycle after the first completes, with no idle cycle.

## Configuration
- MEM_UNSIGNED_LOAD_EN defined:
  - lbu 100100 and lhu 100101 decode as loads, using the same byte/halfword selection but zero-extending.
- Undefined: these opcodes are non-memory ops and pass M.wd through.

## Test plan
- sw, res=0x10, rd2=0x12345678, m_ready tied 1 → m_req=1, m_we=1, m_addr=0x10, byteen=1111, wdata=0x12345678, mem_stall never high.
- sb, res=0x13, rd2=0x000000AB → byteen=1000, wdata=0xABABABAB.
- sh, res=0x12, rd2=0x0000BEEF → byteen=1100, wdata=0xBEEFBEEF.
- lh, res=0x02, rdata=0x80017FFF, zero-wait → wb_wd=0xFFFF8001 one cycle later.
- lb, res=0x01, m_ready after 3 cycles, rdata=0x00007F00 → mem_stall high 3 cycles, m_addr stable, single wb_valid pulse with wb_wd=0x0000007F; following add completes next cycle.
- Reset mid-WAIT → m_req=0 the next cycle, no wb_valid; with MEM_UNSIGNED_LOAD_EN, lbu res=0x03, rdata=0xF0000000 → wb_wd=0x000000F0.
